sd_spi_card_model: RTL

- Single-clock SPI-mode SD card responder. It is the card end of the SPI link that the host-side SD init/read/write logic drives.
- Samples sd_clk, sd_cs and sd_din from the host, decodes command frames and answers on sd_dout.
- Serves single-block reads and writes from a byte-wide backing memory.
- Used for FPGA-in-loop and simulation of the storage hierarchy without a physical card.

---
 rtl/sd_spi_card_model.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_card_model.sv
// sd_spi_card_model: SPI-mode SD card responder serving single-block reads and writes
// from an external byte-wide memory; everything runs on clk with sd_clk oversampled.
module sd_spi_card_model #(
  parameter int INIT_RETRIES = 2,
  parameter int NCR_BYTES = 1,
  parameter int BUSY_BYTES = 4,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sd_clk_i,
  input  logic        sd_cs_i,
  input  logic        sd_din_i,
  output logic        sd_dout_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_en_o,
  input  logic [7:0]  mem_rd_data_i,
  output logic        mem_wr_en_o,
  output logic [7:0]  mem_wr_data_o,
  output logic        card_idle_o,
  output logic [3:0]  state_o
);
  typedef enum logic [3:0] {
    HUNT, CMD_RX, RESP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_WAIT_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_e;
  localparam logic [7:0] NCR = 8'(NCR_BYTES);
  localparam logic [7:0] BUSY = 8'(BUSY_BYTES);
  localparam logic [7:0] RETRY = 8'(INIT_RETRIES);
  localparam logic [8:0] LAST = 9'(BLOCK_BYTES - 1);
  state_e state_q, state_d;
  logic [1:0] sclk_q, cs_q, din_q;
  logic sclk_prev_q;
  logic [2:0] bit_q, bit_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d, r1_q, r1_d, cnt_q, cnt_d, acmd_q, acmd_d, pre_q, wd_q, wd_d;
  logic [5:0] cmd_q, cmd_d;
  logic [22:0] arg_q, arg_d;
  logic [31:0] addr_q, addr_d;
  logic [8:0] idx_q, idx_d;
  logic txv_q, txv_d, long_q, long_d, go_rd_q, go_rd_d, go_wr_q, go_wr_d;
  logic app_q, app_d, idle_q, idle_d, rd_q, rd_d, wr_q, wr_d, pend_q;
  logic cs, rise, fall, done, load;
  logic [7:0] rx_byte, tx_byte, rsp_byte, rsp_len, j;
  assign cs = cs_q[1];
  assign rise = sclk_q[1] & ~sclk_prev_q;
  assign fall = ~sclk_q[1] & sclk_prev_q;
  assign rx_byte = {rx_q, din_q[1]};
  assign done = ~cs & rise & (bit_q == 3'd7);
  assign j = cnt_q - NCR;
  assign rsp_len = NCR + (long_q ? 8'd5 : 8'd1);
  assign rsp_byte = cnt_q < NCR ? 8'hFF : j == 8'd0 ? r1_q : j == 8'd3 ? {4'h0, arg_q[11:8]} :
                    j == 8'd4 ? arg_q[7:0] : 8'h00;
  assign sd_dout_o = cs | ~txv_q | tx_q[7];
  assign mem_addr_o = addr_q;
  assign mem_rd_en_o = rd_q;
  assign mem_wr_en_o = wr_q;
  assign mem_wr_data_o = wd_q;
  assign card_idle_o = idle_q;
  assign state_o = state_q;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    rx_d = rx_q;
    tx_d = tx_q;
    txv_d = txv_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    idx_d = idx_q;
    r1_d = r1_q;
    long_d = long_q;
    go_rd_d = go_rd_q;
    go_wr_d = go_wr_q;
    app_d = app_q;
    idle_d = idle_q;
    acmd_d = acmd_q;
    addr_d = addr_q;
    wd_d = wd_q;
    rd_d = 1'b0;
    wr_d = 1'b0;
    load = 1'b0;
    tx_byte = 8'hFF;
    if (cs) begin
      state_d = HUNT;
      bit_d = 3'd0;
      app_d = 1'b0;
      txv_d = 1'b0;
    end else begin
      if (rise) begin
        rx_d = rx_byte[6:0];
        bit_d = bit_q + 3'd1;
      end
      // the fall right after a byte boundary must keep the freshly loaded MSB
      if (fall && bit_q != 3'd0) tx_d = {tx_q[6:0], 1'b1};
      if (done) begin
        case (state_q)
          HUNT: if (rx_byte[7:6] == 2'b01) begin
            cmd_d = rx_byte[5:0];
            cnt_d = 8'd0;
            state_d = CMD_RX;
          end
          CMD_RX: if (cnt_q != 8'd4) begin
            arg_d = {arg_q[14:0], rx_byte};
            cnt_d = cnt_q + 8'd1;
          end else begin
            r1_d = {5'b0, 1'b1, 1'b0, idle_q};
            long_d = 1'b0;
            go_rd_d = 1'b0;
            go_wr_d = 1'b0;
            app_d = cmd_q == 6'd55;
            if (cmd_q == 6'd0) begin
              r1_d = 8'h01;
              acmd_d = 8'd0;
              idle_d = 1'b1;
            end else if (cmd_q == 6'd8 || cmd_q == 6'd55) begin
              r1_d = {7'b0, idle_q};
              long_d = cmd_q == 6'd8;
            end else if (cmd_q == 6'd41 && app_q) begin
              r1_d = {7'b0, acmd_q < RETRY};
              acmd_d = acmd_q < RETRY ? acmd_q + 8'd1 : acmd_q;
              idle_d = idle_q & (acmd_q < RETRY);
            end else if ((cmd_q == 6'd17 || cmd_q == 6'd24) && !idle_q) begin
              r1_d = 8'h00;
              go_rd_d = cmd_q == 6'd17;
              go_wr_d = cmd_q == 6'd24;
            end
            load = 1'b1;
            tx_byte = (NCR_BYTES > 0) ? 8'hFF : r1_d;
            cnt_d = 8'd1;
            state_d = RESP;
          end
          RESP: if (cnt_q < rsp_len) begin
            load = 1'b1;
            tx_byte = rsp_byte;
            cnt_d = cnt_q + 8'd1;
          end else if (go_rd_q) begin
            load = 1'b1;
            state_d = RD_TOKEN;
          end else begin
            txv_d = 1'b0;
            state_d = go_wr_q ? WR_WAIT_TOKEN : HUNT;
          end
          RD_TOKEN: begin
            load = 1'b1;
            tx_byte = 8'hFE;
            rd_d = 1'b1;
            addr_d = {arg_q, 9'd0};
            idx_d = 9'd0;
            state_d = RD_DATA;
          end
          RD_DATA: begin
            load = 1'b1;
            tx_byte = pre_q;
            if (idx_q == LAST) begin
              cnt_d = 8'd0;
              state_d = RD_CRC;
            end else begin
              rd_d = 1'b1;
              idx_d = idx_q + 9'd1;
              addr_d = {arg_q, idx_q + 9'd1};
            end
          end
          RD_CRC: if (cnt_q < 8'd2) begin
            load = 1'b1;
            cnt_d = cnt_q + 8'd1;
          end else begin
            txv_d = 1'b0;
            state_d = HUNT;
          end
          WR_WAIT_TOKEN: if (rx_byte == 8'hFE) begin
            idx_d = 9'd0;
            state_d = WR_DATA;
          end
          WR_DATA: begin
            wr_d = 1'b1;
            addr_d = {arg_q, idx_q};
            wd_d = rx_byte;
            idx_d = idx_q + 9'd1;
            cnt_d = 8'd0;
            state_d = idx_q == LAST ? WR_CRC : WR_DATA;
          end
          WR_CRC: if (cnt_q == 8'd0) cnt_d = 8'd1;
          else begin
            load = 1'b1;
            tx_byte = 8'h05;
            state_d = WR_RESP;
          end
          WR_RESP: begin
            load = 1'b1;
            tx_byte = 8'h00;
            cnt_d = 8'd1;
            state_d = WR_BUSY;
          end
          WR_BUSY: if (cnt_q <= BUSY) begin
            load = 1'b1;
            tx_byte = cnt_q < BUSY ? 8'h00 : 8'hFF;
            cnt_d = cnt_q + 8'd1;
          end else begin
            txv_d = 1'b0;
            state_d = HUNT;
          end
          default: state_d = HUNT;
        endcase
      end
    end
    if (load) begin
      tx_d = tx_byte;
      txv_d = 1'b1;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_q <= 2'b00;
      cs_q <= 2'b11;
      din_q <= 2'b11;
      sclk_prev_q <= 1'b0;
      state_q <= HUNT;
      bit_q <= 3'd0;
      rx_q <= 7'd0;
      tx_q <= 8'hFF;
      txv_q <= 1'b0;
      cnt_q <= 8'd0;
      cmd_q <= 6'd0;
      arg_q <= 23'd0;
      idx_q <= 9'd0;
      r1_q <= 8'h00;
      long_q <= 1'b0;
      go_rd_q <= 1'b0;
      go_wr_q <= 1'b0;
      app_q <= 1'b0;
      idle_q <= 1'b1;
      acmd_q <= 8'd0;
      addr_q <= 32'd0;
      wd_q <= 8'd0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      pend_q <= 1'b0;
      pre_q <= 8'h00;
    end else begin
      sclk_q <= {sclk_q[0], sd_clk_i};
      cs_q <= {cs_q[0], sd_cs_i};
      din_q <= {din_q[0], sd_din_i};
      sclk_prev_q <= sclk_q[1];
      state_q <= state_d;
      bit_q <= bit_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      txv_q <= txv_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      idx_q <= idx_d;
      r1_q <= r1_d;
      long_q <= long_d;
      go_rd_q <= go_rd_d;
      go_wr_q <= go_wr_d;
      app_q <= app_d;
      idle_q <= idle_d;
      acmd_q <= acmd_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      pend_q <= rd_q;
      if (pend_q) pre_q <= mem_rd_data_i;
    end
  end
endmodule
